// File: rtl/serial_adder_nbit.sv
// Bit-serial N-bit adder: Q = A + B + Cwe, LSB first, one bit per clock through a single
// full-adder cell, with a start/done handshake and a registered, held result.
module serial_adder_nbit #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cwe,
    input  logic         START,
    output logic [N-1:0] Q,
    output logic         Cwy,
    output logic         BUSY,
    output logic         DONE
);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e state_q, state_d;

    logic [N-1:0]  sa_q, sa_d;
    logic [N-1:0]  sb_q, sb_d;
    // Partial sum needs only N-1 bits: the final bit is merged straight into Q.
    logic [N-2:0]  sr_q, sr_d;
    logic [N-1:0]  q_q, q_d;
    logic          c_q, c_d;
    logic          cwy_q, cwy_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          sum_bit;
    logic          carry_bit;
    logic          last_bit;
    logic [N-1:0]  shifted;

    assign sum_bit   = sa_q[0] ^ sb_q[0] ^ c_q;
    assign carry_bit = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
    assign last_bit  = (cnt_q == CW'(N - 1));
    assign shifted   = {sum_bit, sr_q};

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (START) state_d = StRun;
            StRun:   if (last_bit) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        BUSY = (state_q == StRun);
        DONE = (state_q == StFin);
    end

    always_comb begin
        sa_d  = sa_q;
        sb_d  = sb_q;
        sr_d  = sr_q;
        c_d   = c_q;
        cnt_d = cnt_q;
        q_d   = q_q;
        cwy_d = cwy_q;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    sa_d  = A;
                    sb_d  = B;
                    c_d   = Cwe;
                    sr_d  = '0;
                    cnt_d = '0;
                end
            end
            StRun: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                c_d   = carry_bit;
                sr_d  = shifted[N-1:1];
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    q_d   = shifted;
                    cwy_d = carry_bit;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sa_q  <= '0;
            sb_q  <= '0;
            sr_q  <= '0;
            c_q   <= 1'b0;
            cnt_q <= '0;
            q_q   <= '0;
            cwy_q <= 1'b0;
        end else begin
            sa_q  <= sa_d;
            sb_q  <= sb_d;
            sr_q  <= sr_d;
            c_q   <= c_d;
            cnt_q <= cnt_d;
            q_q   <= q_d;
            cwy_q <= cwy_d;
        end
    end

    assign Q   = q_q;
    assign Cwy = cwy_q;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Self-checking bench for serial_adder_nbit at N = 4, 8 and 16: directed handshake/abort cases
// on the 8-bit instance and back-to-back random streams on all three, scored against A+B+Cwe.
module tb_serial_adder_nbit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        st4, st8, st16;
    logic        c4, c8, c16;
    logic [3:0]  a4, b4, q4;
    logic [7:0]  a8, b8, q8;
    logic [15:0] a16, b16, q16;
    logic        cwy4, cwy8, cwy16;
    logic        busy4, busy8, busy16;
    logic        done4, done8, done16;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] sb[$];

    serial_adder_nbit #(.N(4), .CW(3)) u_dut4 (
        .CLK(clk), .RST(rst), .A(a4), .B(b4), .Cwe(c4), .START(st4),
        .Q(q4), .Cwy(cwy4), .BUSY(busy4), .DONE(done4)
    );

    serial_adder_nbit #(.N(8), .CW(4)) u_dut8 (
        .CLK(clk), .RST(rst), .A(a8), .B(b8), .Cwe(c8), .START(st8),
        .Q(q8), .Cwy(cwy8), .BUSY(busy8), .DONE(done8)
    );

    serial_adder_nbit #(.N(16), .CW(5)) u_dut16 (
        .CLK(clk), .RST(rst), .A(a16), .B(b16), .Cwe(c16), .START(st16),
        .Q(q16), .Cwy(cwy16), .BUSY(busy16), .DONE(done16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] golden(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic c);
        logic [31:0] m;
        m = (32'd1 << w) - 32'd1;
        return (a & m) + (b & m) + {31'b0, c};
    endfunction

    task automatic drive(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic st);
        case (w)
            4:       begin a4 = a[3:0];   b4 = b[3:0];   c4 = c;  st4 = st;  end
            8:       begin a8 = a[7:0];   b8 = b[7:0];   c8 = c;  st8 = st;  end
            default: begin a16 = a[15:0]; b16 = b[15:0]; c16 = c; st16 = st; end
        endcase
    endtask

    // Result packed as {Cwy, Q} so it compares directly against golden().
    task automatic get_out(input int w, output logic [31:0] res, output logic busy,
                           output logic done);
        case (w)
            4:       begin res = {27'b0, cwy4, q4};   busy = busy4;  done = done4;  end
            8:       begin res = {23'b0, cwy8, q8};   busy = busy8;  done = done8;  end
            default: begin res = {15'b0, cwy16, q16}; busy = busy16; done = done16; end
        endcase
    endtask

    task automatic start_op(input int w, input logic [31:0] a, input logic [31:0] b,
                            input logic c);
        logic [31:0] res;
        logic        busy, done;
        @(negedge clk);
        drive(w, a, b, c, 1'b1);
        sb.push_back(golden(w, a, b, c));
        @(negedge clk);
        drive(w, a, b, c, 1'b0);
        get_out(w, res, busy, done);
        check("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    // Waits (bounded) for DONE; c0/b0 are negedges and BUSY cycles already elapsed.
    task automatic wait_result(input int w, input int exp_lat, input int c0, input int b0);
        int          c;
        int          bn;
        bit          got;
        logic [31:0] res, prev, exp;
        logic        busy, done;
        c   = c0;
        bn  = b0;
        got = 1'b0;
        get_out(w, prev, busy, done);
        while (!got && c < w + 6) begin
            @(negedge clk);
            c++;
            get_out(w, res, busy, done);
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) bn++;
                check("q_hold", res, prev);
            end
        end
        check("done_seen", {31'b0, got}, 32'd1);
        if (got) begin
            check("latency", c, exp_lat);
            check("busy_cycles", bn, w);
            check("sb_depth", sb.size(), 32'd1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check("result", res, exp);
            end
        end
    endtask

    task automatic no_done(input int w, input int n);
        logic [31:0] res;
        logic        busy, done;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            get_out(w, res, busy, done);
            check("no_done", {31'b0, done}, 32'd0);
            check("no_busy", {31'b0, busy}, 32'd0);
        end
    endtask

    task automatic run_random(input int w, input int n_ops);
        logic [31:0] a, b;
        logic        c;
        a = '0;
        b = '0;
        c = 1'b0;
        @(negedge clk);
        for (int i = 0; i < n_ops; i++) begin
            a = $urandom;
            b = $urandom;
            c = 1'($urandom_range(0, 1));
            drive(w, a, b, c, 1'b1);
            sb.push_back(golden(w, a, b, c));
            wait_result(w, (i == 0) ? w + 1 : w + 2, 0, 0);
        end
        drive(w, a, b, c, 1'b0);
    endtask

    initial begin
        logic [31:0] res;
        logic        busy, done;

        rst = 1'b1;
        drive(4, 0, 0, 1'b0, 1'b0);
        drive(16, 0, 0, 1'b0, 1'b0);
        drive(8, 32'hFF, 0, 1'b0, 1'b1);
        repeat (2) begin
            @(negedge clk);
            get_out(8, res, busy, done);
            check("reset_q", res, 32'h0);
            check("reset_busy", {31'b0, busy}, 32'd0);
            check("reset_done", {31'b0, done}, 32'd0);
        end
        rst = 1'b0;
        drive(8, 32'hFF, 0, 1'b0, 1'b0);
        @(negedge clk);
        get_out(8, res, busy, done);
        check("no_op_after_reset", {31'b0, busy}, 32'd0);
        check("reset_q_hold", res, 32'h0);

        // Basic add: DONE 9 negedges after the START drive
        start_op(8, 32'd23, 32'd42, 1'b0);
        wait_result(8, 9, 1, 1);
        no_done(8, 1);

        start_op(8, 32'hFF, 32'h00, 1'b1);
        wait_result(8, 9, 1, 1);
        start_op(8, 32'h80, 32'h80, 1'b0);
        wait_result(8, 9, 1, 1);

        // START pulse and operand change mid-run must be ignored
        @(negedge clk);
        drive(8, 32'h0F, 32'h01, 1'b0, 1'b1);
        sb.push_back(golden(8, 32'h0F, 32'h01, 1'b0));
        @(negedge clk);
        drive(8, 32'h0F, 32'h01, 1'b0, 1'b0);
        @(negedge clk);
        drive(8, 32'hAA, 32'h55, 1'b0, 1'b1);
        @(negedge clk);
        drive(8, 32'hAA, 32'h55, 1'b0, 1'b0);
        wait_result(8, 9, 3, 3);
        no_done(8, 12);

        // Abort on the 4th RUN edge
        start_op(8, 32'h3C, 32'h3C, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        get_out(8, res, busy, done);
        check("abort_q", res, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        no_done(8, 12);
        start_op(8, 32'h01, 32'h02, 1'b1);
        wait_result(8, 9, 1, 1);

        run_random(8, 200);
        run_random(4, 200);
        run_random(16, 200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_adder_nbit.md
Name: serial_adder_nbit

Overview:
- Bit-serial N-bit adder computing Q = A + B + Cwe, LSB first, one bit per clock, through a single full-adder cell and a carry flip-flop.
- Addition counterpart to the 1-bit subtractor cell: same operand/carry naming (A, B, Cwe in; Q, Cwy out).
- Intended as the accumulate stage of the shift-and-add multiplier in the same directory, where area matters more than latency.
- Start/done handshake; result registered and held stable between operations.

Parameters:
- N, 8, operand and result width in bits (N >= 2).
- CW, 4, width of internal bit counter; must satisfy 2^CW > N.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- A  input  N  augend; sampled only on accepted START.
- B  input  N  addend; sampled only on accepted START.
- Cwe  input  1  carry-in; sampled only on accepted START.
- START  input  1  request; accepted only when state is IDLE.
- Q  output  N  sum; registered, updated once per operation.
- Cwy  output  1  carry-out of MSB; registered, updated together with Q.
- BUSY  output  1  high while state is RUN.
- DONE  output  1  one-cycle pulse when Q/Cwy have just been updated.

Behaviour:
- Reset: on any edge with RST=1, state=IDLE, Q=0, Cwy=0, BUSY=0, DONE=0, counter=0, carry reg=0, shift regs=0. RST has priority over START and all other inputs.
- States: IDLE, RUN, FIN.
- IDLE, START=1: load SA<=A, SB<=B, C<=Cwe, SR<=0, cnt<=0; go to RUN. START=0: stay. Q/Cwy hold.
- RUN, each edge:
  - s = SA[0]^SB[0]^C; C <= maj(SA[0],SB[0],C).
  - SA, SB shift right by 1.
  - SR <= {s, SR[N-1:1]} (result enters at MSB, so after N shifts SR[0] is bit 0).
  - cnt <= cnt+1.
  - On the edge where cnt == N-1: Q <= SR-with-final-bit, Cwy <= final carry (new C); go to FIN.
- FIN: DONE=1 for exactly this cycle; next edge go to IDLE unconditionally.
- Output decode: BUSY = (state==RUN); DONE = (state==FIN). Both decoded from registered state, glitch-free at edges.
- Timing: START accepted at edge k; RUN occupies edges k+1..k+N; Q/Cwy valid and DONE high in the cycle after edge k+N. A new START is accepted earliest at edge k+N+2 (the first edge with state IDLE). Total N+2 cycles per operation.
- START during RUN or FIN: ignored, not queued. A, B, Cwe changes during RUN have no effect.
- Arithmetic: modulo 2^N on Q, overflow reported only via Cwy (unsigned carry). No signed overflow flag.
- Q and Cwy change only at the completing edge or on reset; never mid-operation.
- Reset mid-operation aborts the operation. Q/Cwy go to 0, no DONE pulse, and the next START is accepted at the first edge with RST=0.
- Back-to-back: START held high continuously yields one operation every N+2 cycles.

Test Plan:
- Reset: RST=1 for 2 cycles with START=1, A=8'hFF -> Q=0, Cwy=0, BUSY=0, DONE=0; no operation started.
- Basic add: A=8'd23, B=8'd42, Cwe=0, START one cycle -> BUSY high 8 cycles, then DONE pulse 1 cycle; Q=8'd65, Cwy=0; DONE exactly 9 cycles after the START edge.
- Carry chain: A=8'hFF, B=8'h00, Cwe=1 -> Q=8'h00, Cwy=1. Also A=8'h80, B=8'h80, Cwe=0 -> Q=8'h00, Cwy=1.
- Ignored START and input stability: start A=8'h0F, B=8'h01. During RUN pulse START and change A=8'hAA, B=8'h55 -> result Q=8'h10, Cwy=0. Exactly one DONE pulse; Q unchanged before DONE.
- Abort: START A=8'h3C, B=8'h3C. Assert RST at the 4th RUN cycle -> Q=0, Cwy=0, no DONE. Then START A=8'h01, B=8'h02, Cwe=1 -> Q=8'h04, Cwy=0.
- Random/back-to-back: START held high, 200 random (A,B,Cwe) triples -> each result matches a golden {Cwy,Q} = A+B+Cwe. Operation period is exactly N+2 cycles; repeat with N=4 and N=16.
